// File: rtl/clock_ctrl_pkg.sv
// clock_pkg: shared widths, field limits, mode state codes and a wrapping
// increment helper for the time-of-day controller.
// Ports: none (package).
// Optional feature macro used by the design: CLOCK_CTRL_ALARM_EN.
package clock_pkg;
    localparam int SEC_W = 6;
    localparam int MIN_W = 6;
    localparam int HR_W  = 5;

    localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;
    localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;
    localparam logic [HR_W-1:0]  HR_MAX  = 5'd23;

    typedef enum logic [2:0] {
        RUN        = 3'd0,
        SET_HR     = 3'd1,
        SET_MIN    = 3'd2,
        SET_AL_HR  = 3'd3,
        SET_AL_MIN = 3'd4
    } mode_t;

    // Adds one and wraps to zero after max; callers size-cast in and out.
    function automatic logic [7:0] wrap_inc(input logic [7:0] v, input logic [7:0] max);
        return (v == max) ? 8'd0 : v + 8'd1;
    endfunction
endpackage

// File: rtl/clock_ctrl_if.sv
// clock_ctrl_if: button inputs and time/status outputs of the clock controller.
// Signals: btn_mode, btn_inc (conditioned button levels), seconds, minutes,
// hours, mode, tick, blink, and alarm_hit when CLOCK_CTRL_ALARM_EN is defined.
// master = environment driving buttons, slave = clock_ctrl.
interface clock_ctrl_if;
    import clock_pkg::*;
    logic             btn_mode;
    logic             btn_inc;
    logic [SEC_W-1:0] seconds;
    logic [MIN_W-1:0] minutes;
    logic [HR_W-1:0]  hours;
    logic [2:0]       mode;
    logic             tick;
    logic             blink;
`ifdef CLOCK_CTRL_ALARM_EN
    logic             alarm_hit;
    modport master (output btn_mode, btn_inc,
                    input  seconds, minutes, hours, mode, tick, blink, alarm_hit);
    modport slave  (input  btn_mode, btn_inc,
                    output seconds, minutes, hours, mode, tick, blink, alarm_hit);
`else
    modport master (output btn_mode, btn_inc,
                    input  seconds, minutes, hours, mode, tick, blink);
    modport slave  (input  btn_mode, btn_inc,
                    output seconds, minutes, hours, mode, tick, blink);
`endif
endinterface

// File: rtl/clock_ctrl_time_counter.sv
// time_counter: hh:mm:ss registers with all wrap logic.
// Ports: clk, rst_n (async active-low), adv (advance one second),
// inc_hr / inc_min (edit strobes), clr_sec (zero seconds),
// seconds / minutes / hours (registered time).
module time_counter
    import clock_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             adv,
    input  logic             inc_hr,
    input  logic             inc_min,
    input  logic             clr_sec,
    output logic [SEC_W-1:0] seconds,
    output logic [MIN_W-1:0] minutes,
    output logic [HR_W-1:0]  hours
);
    logic sec_wrap, min_wrap;

    assign sec_wrap = adv && seconds == SEC_MAX;
    assign min_wrap = sec_wrap && minutes == MIN_MAX;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seconds <= '0;
            minutes <= '0;
            hours   <= '0;
        end else begin
            if (clr_sec)
                seconds <= '0;
            else if (adv)
                seconds <= SEC_W'(wrap_inc(8'(seconds), 8'(SEC_MAX)));
            if (sec_wrap || inc_min)
                minutes <= MIN_W'(wrap_inc(8'(minutes), 8'(MIN_MAX)));
            if (min_wrap || inc_hr)
                hours <= HR_W'(wrap_inc(8'(hours), 8'(HR_MAX)));
        end
    end
endmodule

// File: rtl/clock_ctrl.sv
// clock_ctrl: 1 Hz prescaler, button edge detection and set-mode FSM that
// sequences the time_counter; optional alarm comparator.
// Ports: clk, rst_n (async active-low), bus (clock_ctrl_if.slave: buttons in,
// time/mode/tick/blink out, alarm_hit out with CLOCK_CTRL_ALARM_EN).
// Parameter TICK_DIV: clk cycles per one-second tick (>= 2).
// Macro CLOCK_CTRL_ALARM_EN adds alarm registers, SET_AL_* states and alarm_hit.
module clock_ctrl
    import clock_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic         clk,
    input  logic         rst_n,
    clock_ctrl_if.slave  bus
);
    localparam int            PW   = $clog2(TICK_DIV);
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);
`ifdef CLOCK_CTRL_ALARM_EN
    localparam mode_t LAST_SET = SET_AL_MIN;
`else
    localparam mode_t LAST_SET = SET_MIN;
`endif

    mode_t            state, state_n;
    logic [PW-1:0]    cnt, cnt_n;
    logic             tick, blink, mode_q, inc_q;
    logic             mode_p, inc_p, leave_set, adv;
    logic [SEC_W-1:0] seconds;
    logic [MIN_W-1:0] minutes;
    logic [HR_W-1:0]  hours;

    assign mode_p    = bus.btn_mode & ~mode_q;
    // A mode press in the same cycle wins over an inc press.
    assign inc_p     = bus.btn_inc & ~inc_q & ~mode_p;
    assign leave_set = mode_p && state == LAST_SET;
    assign adv       = tick && state == RUN;
    // Leaving edit mode restarts the second so the next tick is a full period away.
    assign cnt_n     = (leave_set || cnt == LAST) ? '0 : cnt + PW'(1);

    always_comb begin
        state_n = state;
        if (mode_p) begin
            case (state)
                RUN:        state_n = SET_HR;
                SET_HR:     state_n = SET_MIN;
`ifdef CLOCK_CTRL_ALARM_EN
                SET_MIN:    state_n = SET_AL_HR;
                SET_AL_HR:  state_n = SET_AL_MIN;
                SET_AL_MIN: state_n = RUN;
`else
                SET_MIN:    state_n = RUN;
`endif
                default:    state_n = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= RUN;
            cnt    <= '0;
            tick   <= 1'b0;
            blink  <= 1'b0;
            mode_q <= 1'b0;
            inc_q  <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            tick   <= cnt_n == LAST;
            mode_q <= bus.btn_mode;
            inc_q  <= bus.btn_inc;
            blink  <= state_n == RUN ? 1'b0 : state_n != state ? 1'b1 : blink ^ tick;
        end
    end

    time_counter u_time (
        .clk     (clk),
        .rst_n   (rst_n),
        .adv     (adv),
        .inc_hr  (inc_p && state == SET_HR),
        .inc_min (inc_p && state == SET_MIN),
        .clr_sec (leave_set),
        .seconds (seconds),
        .minutes (minutes),
        .hours   (hours)
    );

`ifdef CLOCK_CTRL_ALARM_EN
    logic [HR_W-1:0]  al_hr;
    logic [MIN_W-1:0] al_min;
    logic             match, ack, alarm_hit;

    assign match = state == RUN && hours == al_hr && minutes == al_min;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            al_hr     <= '0;
            al_min    <= '0;
            ack       <= 1'b0;
            alarm_hit <= 1'b0;
        end else begin
            if (inc_p && state == SET_AL_HR)
                al_hr <= HR_W'(wrap_inc(8'(al_hr), 8'(HR_MAX)));
            if (inc_p && state == SET_AL_MIN)
                al_min <= MIN_W'(wrap_inc(8'(al_min), 8'(MIN_MAX)));
            // An acknowledge holds the alarm off until the match window ends.
            ack       <= match && (ack || inc_p);
            alarm_hit <= match && !ack && !inc_p && state_n == RUN;
        end
    end

    assign bus.alarm_hit = alarm_hit;
`endif

    assign bus.seconds = seconds;
    assign bus.minutes = minutes;
    assign bus.hours   = hours;
    assign bus.mode    = state;
    assign bus.tick    = tick;
    assign bus.blink   = blink;
endmodule

// File: tb/tb_clock_ctrl.sv
// tb_clock_ctrl: directed self-checking bench for clock_ctrl with TICK_DIV=4.
// Covers reset state, tick cadence, hour/minute editing and wrap, frozen time,
// blink behaviour, simultaneous presses, held buttons, exit timing, the
// 23:59:59 rollover, mid-edit reset and (with CLOCK_CTRL_ALARM_EN) the alarm.
module tb_clock_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail = 0;

    clock_ctrl_if bus ();

    clock_ctrl #(.TICK_DIV(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press_mode();
        bus.btn_mode = 1'b1;
        step();
        bus.btn_mode = 1'b0;
        step();
    endtask

    task automatic press_inc(input int n);
        for (int i = 0; i < n; i++) begin
            bus.btn_inc = 1'b1;
            step();
            bus.btn_inc = 1'b0;
            step();
        end
    endtask

    // From SET_MIN back to RUN; the last mode press is the exit edge.
    task automatic exit_to_run();
`ifdef CLOCK_CTRL_ALARM_EN
        press_mode();
        press_mode();
`endif
        press_mode();
    endtask

    initial begin
        logic b;
        logic found;
        rst_n = 1'b0;
        bus.btn_mode = 1'b0;
        bus.btn_inc = 1'b0;
        step();
        step();
        chk("rst_sec", 32'(bus.seconds), 0);
        chk("rst_min", 32'(bus.minutes), 0);
        chk("rst_hr", 32'(bus.hours), 0);
        chk("rst_mode", 32'(bus.mode), 0);
        chk("rst_tick", 32'(bus.tick), 0);
        chk("rst_blink", 32'(bus.blink), 0);
        rst_n = 1'b1;
        step();
        chk("tick_c1", 32'(bus.tick), 0);
        step();
        chk("tick_c2", 32'(bus.tick), 0);
        step();
        chk("tick_c3", 32'(bus.tick), 1);
        chk("sec_before_adv", 32'(bus.seconds), 0);
        step();
        chk("sec_after_adv", 32'(bus.seconds), 1);
        chk("tick_c4", 32'(bus.tick), 0);

        bus.btn_mode = 1'b1;
        step();
        chk("enter_set_hr", 32'(bus.mode), 1);
        chk("blink_on_entry", 32'(bus.blink), 1);
        bus.btn_mode = 1'b0;
        step();
        press_inc(23);
        chk("hr_23", 32'(bus.hours), 23);
        press_inc(1);
        chk("hr_wrap", 32'(bus.hours), 0);
        press_inc(1);
        chk("hr_1", 32'(bus.hours), 1);
        chk("sec_frozen", 32'(bus.seconds), 1);

        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            if (bus.tick) found = 1'b1;
            else step();
        end
        chk("tick_seen_in_set", 32'(found), 1);
        b = bus.blink;
        step();
        chk("blink_toggle", 32'(bus.blink), 32'(!b));

        bus.btn_mode = 1'b1;
        bus.btn_inc = 1'b1;
        step();
        chk("simul_mode", 32'(bus.mode), 2);
        chk("simul_hr", 32'(bus.hours), 1);
        chk("simul_min", 32'(bus.minutes), 0);
        bus.btn_mode = 1'b0;
        bus.btn_inc = 1'b0;
        step();

        bus.btn_inc = 1'b1;
        repeat (10) step();
        bus.btn_inc = 1'b0;
        step();
        chk("held_inc", 32'(bus.minutes), 1);
        press_inc(58);
        chk("min_59", 32'(bus.minutes), 59);
        press_inc(1);
        chk("min_wrap", 32'(bus.minutes), 0);
        chk("min_wrap_hr", 32'(bus.hours), 1);

        exit_to_run();
        chk("exit_mode", 32'(bus.mode), 0);
        chk("exit_sec", 32'(bus.seconds), 0);
        chk("exit_blink", 32'(bus.blink), 0);
        chk("exit_tick1", 32'(bus.tick), 0);
        step();
        chk("exit_tick2", 32'(bus.tick), 0);
        step();
        chk("exit_tick3", 32'(bus.tick), 1);
        step();
        chk("exit_sec1", 32'(bus.seconds), 1);

        press_mode();
        press_inc(22);
        chk("set_hr_23", 32'(bus.hours), 23);
        press_mode();
        press_inc(59);
        chk("set_min_59", 32'(bus.minutes), 59);
        exit_to_run();
        repeat (231) step();
        chk("t58_sec", 32'(bus.seconds), 58);
        chk("t58_min", 32'(bus.minutes), 59);
        chk("t58_hr", 32'(bus.hours), 23);
        repeat (3) step();
        chk("t59_tick", 32'(bus.tick), 1);
        step();
        chk("t59_sec", 32'(bus.seconds), 59);
        repeat (4) step();
        chk("wrap_sec", 32'(bus.seconds), 0);
        chk("wrap_min", 32'(bus.minutes), 0);
        chk("wrap_hr", 32'(bus.hours), 0);

        press_mode();
        press_mode();
        press_inc(30);
        chk("pre_rst_min", 32'(bus.minutes), 30);
        chk("pre_rst_mode", 32'(bus.mode), 2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_mode", 32'(bus.mode), 0);
        chk("mid_rst_min", 32'(bus.minutes), 0);
        chk("mid_rst_hr", 32'(bus.hours), 0);
        chk("mid_rst_sec", 32'(bus.seconds), 0);
        chk("mid_rst_blink", 32'(bus.blink), 0);
        chk("mid_rst_tick", 32'(bus.tick), 0);
        step();
        rst_n = 1'b1;
        step();
        chk("rel_tick1", 32'(bus.tick), 0);
        step();
        chk("rel_tick2", 32'(bus.tick), 0);
        step();
        chk("rel_tick3", 32'(bus.tick), 1);
        chk("rel_min", 32'(bus.minutes), 0);
        step();

`ifdef CLOCK_CTRL_ALARM_EN
        press_mode();
        press_mode();
        press_mode();
        chk("al_hr_state", 32'(bus.mode), 3);
        press_mode();
        chk("al_min_state", 32'(bus.mode), 4);
        press_inc(1);
        press_mode();
        chk("al_exit_mode", 32'(bus.mode), 0);
        chk("al_exit_sec", 32'(bus.seconds), 0);
        repeat (238) step();
        chk("al_pre_min", 32'(bus.minutes), 0);
        chk("al_pre_hit", 32'(bus.alarm_hit), 0);
        step();
        chk("al_match_min", 32'(bus.minutes), 1);
        chk("al_match_hit", 32'(bus.alarm_hit), 0);
        step();
        chk("al_hit_rise", 32'(bus.alarm_hit), 1);
        bus.btn_inc = 1'b1;
        step();
        chk("al_ack", 32'(bus.alarm_hit), 0);
        bus.btn_inc = 1'b0;
        step();
        repeat (233) step();
        chk("al_159_sec", 32'(bus.seconds), 59);
        chk("al_159_hit", 32'(bus.alarm_hit), 0);
        repeat (4) step();
        chk("al_200_min", 32'(bus.minutes), 2);
        chk("al_200_hit", 32'(bus.alarm_hit), 0);
        step();
        chk("al_201_hit", 32'(bus.alarm_hit), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
